instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming RV32I instruction encoder and program loader, the inverse of the control/decode path. Accepts per-instruction field bundles (format, registers, funct3, alt bit, immediate) over a valid/ready handshake. Emits packed 32-bit instruction words with a sequential word address, to be written into instruction memory. Used by the testbench/boot path to build programs in instruction memory without a hex file.

Parameters:
ADDR_W, 6, width of the word-address counter
DEPTH, 64, maximum words per program (must be ≤ 2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begin new program at address 0
finish  input  1  single-cycle pulse; close current program
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept bundle
fmt  input  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5..7 illegal
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
alt  input  1  R-type: funct7=0100000 when 1, else 0000000
imm  input  32  signed immediate (byte offset for BRANCH)
out_valid  output  1  encoded word valid
out_ready  input  1  memory side accepts word
out_addr  output  ADDR_W  word address of out_instr
out_instr  output  32  encoded instruction
full  output  1  DEPTH words emitted
done  output  1  one-cycle pulse when program closed
err  output  1  sticky; illegal bundle dropped since last start

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. in_ready, out_valid, full, done, err = 0; out_addr, out_instr = 0; counter = 0.
- FSM states: IDLE, LOAD, FULL, DRAIN.
- IDLE: in_ready=0. On start: counter←0, err←0, go to LOAD.
- LOAD: in_ready = !out_valid || out_ready (single output register, no bubble at full throughput).
- Bundle accepted on in_valid&&in_ready at cycle N: out_instr/out_addr valid at N+1. Latency 1.
- Output word held stable while out_valid && !out_ready.
- Counter increments on each output handshake.
- When the handshake makes the count equal DEPTH: go to FULL. In FULL, full=1 and in_ready=0.
- finish in LOAD or FULL:
  - Output register empty: go to IDLE and pulse done the next cycle.
  - Output word pending: go to DRAIN; in DRAIN, in_ready=0.
  - DRAIN leaves on the final handshake: go to IDLE, pulse done.
- start outside IDLE is ignored.
- finish in IDLE is ignored.
- start and finish in the same cycle: finish wins.
- Encoding: opcodes R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011.
  - R: funct7 from alt.
  - I/LOAD: imm[11:0] placed in bits 31:20.
  - STORE: imm[11:5]→31:25, imm[4:0]→11:7.
  - BRANCH: imm[12]→31, imm[10:5]→30:25, imm[4:1]→11:8, imm[11]→7; imm[0] ignored.
  - Immediate bits above the field width are discarded.
- Illegal fmt: bundle consumed (handshake completes), no word emitted, counter unchanged, err←1.
- Reset mid-program: all state discarded, counter 0.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: the bundle is treated as illegal (dropped, err set) when:
  - I/LOAD/STORE imm is outside −2048..2047, or
  - BRANCH imm is outside −4096..4094, or BRANCH imm[0]=1.
- Undefined: no range check; immediates truncate silently.

Decomposition:
- Shared package holds:
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - fmt code constants FMT_R..FMT_BRANCH;
  - FSM state encoding.
- One natural sub-module: instr_pack, purely combinational. Maps fmt + fields to a 32-bit word plus an illegal flag, including the range check. instr_encoder owns the FSM, counter and output register.

Test Plan:
- Reset then start; R, rd=3, rs1=1, rs2=2, funct3=0, alt=0 → out_instr 0x002081B3 at out_addr 0. With alt=1 → 0x402081B3 at addr 1.
- LOAD rd=5, rs1=2, funct3=2, imm=8 → 0x00812283. STORE rs2=5, rs1=2, funct3=2, imm=12 → 0x00512623.
- BRANCH rs1=1, rs2=2, funct3=0, imm=−4 → 0xFE208EE3.
- out_ready held 0 for 5 cycles with in_valid=1 → out_instr stable, in_ready=0, and exactly one word per handshake thereafter. Back-to-back with out_ready=1 → one word per cycle.
- DEPTH=4: six valid bundles → four words at addr 0..3, full=1, in_ready=0. finish → done pulses once, state IDLE.
- fmt=6 mid-stream → no word, address not advanced, err=1 until next start. With IMM_RANGE_CHECK_EN, I-ALU imm=2048 → dropped, err=1.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder / program loader.
//   - RV32I major opcodes for the supported instruction formats
//   - fmt codes carried on the input bundle
//   - field widths and loader FSM state encoding
package instr_encoder_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned FMT_W   = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned F7_W    = 7;

  // Major opcodes
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  // funct7 values selected by the alt bit on R-type
  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  // Bundle format codes; anything above FMT_BRANCH is illegal
  localparam logic [FMT_W-1:0] FMT_R      = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I      = 3'd1;
  localparam logic [FMT_W-1:0] FMT_LOAD   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_STORE  = 3'd3;
  localparam logic [FMT_W-1:0] FMT_BRANCH = 3'd4;

  // Loader FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: purely combinational field packer.
// Maps a format code plus register/funct/immediate fields to a 32-bit RV32I
// word and flags bundles that cannot be encoded.
// Optional macro IMM_RANGE_CHECK_EN: when defined, out-of-range immediates
// (and odd branch offsets) are flagged illegal instead of silently truncated.
// Ports:
//   fmt_i     bundle format (0=R,1=I-ALU,2=LOAD,3=STORE,4=BRANCH)
//   rd_i      destination register
//   rs1_i     source register 1
//   rs2_i     source register 2
//   funct3_i  funct3 field
//   alt_i     R-type funct7 select
//   imm_i     signed immediate (byte offset for BRANCH)
//   word_o    packed instruction word (combinational)
//   illegal_o bundle cannot be encoded (combinational)
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [FMT_W-1:0] fmt_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [F3_W-1:0]  funct3_i,
  input  logic             alt_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic [XLEN-1:0]  word_o,
  output logic             illegal_o
);

  logic [F7_W-1:0] funct7;

`ifdef IMM_RANGE_CHECK_EN
  logic fits12;
  logic fits13;

  // A value fits an N-bit signed field when all bits from N-1 upward agree
  assign fits12 = (&imm_i[XLEN-1:11]) | ~(|imm_i[XLEN-1:11]);
  assign fits13 = (&imm_i[XLEN-1:12]) | ~(|imm_i[XLEN-1:12]);
`else
  // Upper immediate bits and branch bit 0 are deliberately discarded here
  logic unused_imm;
  assign unused_imm = ^{imm_i[XLEN-1:13], imm_i[0]};
`endif

  // Format mux; illegal codes produce a zero word with the flag raised
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    funct7    = alt_i ? F7_ALT : F7_BASE;
    case (fmt_i)
      FMT_R:      word_o = {funct7, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      FMT_I:      word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
      FMT_LOAD:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
      FMT_STORE:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:0], OP_STORE};
      FMT_BRANCH: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OP_BRANCH};
      default:    illegal_o = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    // I/LOAD/STORE: -2048..2047; BRANCH: -4096..4094 and even
    if ((fmt_i == FMT_I || fmt_i == FMT_LOAD || fmt_i == FMT_STORE) && !fits12) begin
      illegal_o = 1'b1;
    end
    if (fmt_i == FMT_BRANCH && (!fits13 || imm_i[0])) begin
      illegal_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder / program loader.
// Accepts field bundles over valid/ready, emits packed instruction words with
// sequential word addresses through a single output register (latency 1,
// full throughput). A program is opened by start and closed by finish.
// Optional macro IMM_RANGE_CHECK_EN (see instr_pack) drops out-of-range
// immediates as illegal bundles.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-low reset
//   start      pulse: open a new program at address 0 (IDLE only)
//   finish     pulse: close the current program (wins over start)
//   in_valid / in_ready            bundle handshake
//   fmt, rd, rs1, rs2, funct3, alt, imm   bundle fields
//   out_valid / out_ready          word handshake
//   out_addr, out_instr            word address and encoded word
//   full       DEPTH words emitted
//   done       one-cycle pulse when the program is closed
//   err        sticky: an illegal bundle was dropped since last start
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMT_W-1:0]  fmt,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [F3_W-1:0]   funct3,
  input  logic              alt,
  input  logic [XLEN-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [XLEN-1:0]   out_instr,
  output logic              full,
  output logic              done,
  output logic              err
);

  // Counter needs one extra bit so that DEPTH == 2**ADDR_W is representable
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [XLEN-1:0]     out_instr_q, out_instr_d;
  logic                full_q,      full_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;

  logic                in_ready_c;
  logic                in_hs;
  logic                out_hs;
  logic [XLEN-1:0]     pack_word;
  logic                pack_illegal;

  instr_pack u_pack (
    .fmt_i     (fmt),
    .rd_i      (rd),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .funct3_i  (funct3),
    .alt_i     (alt),
    .imm_i     (imm),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  // Ready is combinational on out_ready so the single output register can
  // refill in the same cycle it drains. A bundle is only taken if the word
  // it might produce still has an address below DEPTH.
  always_comb begin
    in_ready_c = 1'b0;
    if (state_q == ST_LOAD) begin
      in_ready_c = !out_valid_q ||
                   (out_ready && (count_q < CNT_W'(DEPTH - 1)));
    end
  end

  assign in_hs  = in_valid && in_ready_c;
  assign out_hs = out_valid_q && out_ready;

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    err_d       = err_q;
    done_d      = 1'b0;

    // Word leaves the output register
    if (out_hs) begin
      out_valid_d = 1'b0;
      count_d     = count_q + CNT_W'(1);
    end

    // Bundle enters; illegal bundles are consumed without producing a word
    if (in_hs) begin
      if (pack_illegal) begin
        err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_instr_d = pack_word;
        out_addr_d  = ADDR_W'(count_d);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !finish) begin
          state_d = ST_LOAD;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD, ST_FULL: begin
        if (finish) begin
          if (out_valid_d) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (state_q == ST_LOAD && count_d == CNT_W'(DEPTH)) begin
          state_d = ST_FULL;
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    full_d = (state_d == ST_FULL);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
      full_q      <= full_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_instr = out_instr_q;
  assign full      = full_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program vectors followed by
// randomized bundles/handshakes, compared against a transaction-level model
// (expected-word queue, word counts and a three-phase program view).
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, finish;
  logic              in_valid, in_ready;
  logic [2:0]        fmt;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic              alt;
  logic [31:0]       imm;
  logic              out_valid, out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;
  logic              full, done, err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .alt(alt), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .full(full), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   m_phase;    // 0 = no program, 1 = program open, 2 = closing with a word left
  int   m_emitted;  // words handed to memory in this program
  int   m_loaded;   // legal bundles accepted in this program
  logic m_err, m_done, m_full;

  function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [2:0] f3, input logic a,
                                           input logic [31:0] im);
    logic [31:0] w;
    w = (32'(f3) << 12) | (32'(s1) << 15);
    case (f)
      3'd0: w = w | 32'h33 | (32'(d) << 7) | (32'(s2) << 20) | (a ? 32'h4000_0000 : 32'h0);
      3'd1: w = w | 32'h13 | (32'(d) << 7) | ((im & 32'hFFF) << 20);
      3'd2: w = w | 32'h03 | (32'(d) << 7) | ((im & 32'hFFF) << 20);
      3'd3: w = w | 32'h23 | ((im & 32'd31) << 7) | (32'(s2) << 20)
                  | (((im >> 5) & 32'd127) << 25);
      3'd4: w = w | 32'h63 | (((im >> 11) & 32'd1) << 7) | (((im >> 1) & 32'd15) << 8)
                  | (32'(s2) << 20) | (((im >> 5) & 32'd63) << 25)
                  | (((im >> 12) & 32'd1) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic ref_legal(input logic [2:0] f, input logic [31:0] im);
    if (f > 3'd4) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    if (f >= 3'd1 && f <= 3'd3)
      return ($signed(im) >= -2048) && ($signed(im) <= 2047);
    if (f == 3'd4)
      return ($signed(im) >= -4096) && ($signed(im) <= 4094) && (im[0] == 1'b0);
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_phase = 0; m_emitted = 0; m_loaded = 0;
    m_err = 1'b0; m_done = 1'b0; m_full = 1'b0;
  endtask

  task automatic set_b(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic a,
                       input logic [31:0] im);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; alt = a; imm = im;
  endtask

  // One clock: drive inputs just after a falling edge, check pre-edge outputs,
  // advance the model, then check registered flags after the next falling edge.
  task automatic step(input logic v, input logic ordy, input logic st, input logic fin);
    logic exp_ready, in_hs, out_hs, legal;
    logic [31:0] w;
    in_valid = v; out_ready = ordy; start = st; finish = fin;
    #1;
    exp_ready = (m_phase == 1) && (m_loaded < int'(DEPTH)) && (sb.size() == 0 || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0 && out_valid) begin
      check("out_addr", 32'(out_addr), sb[0].addr);
      check("out_instr", out_instr, sb[0].word);
    end
    out_hs = (sb.size() != 0) && ordy;
    in_hs  = v && exp_ready;
    w      = ref_word(fmt, rd, rs1, rs2, funct3, alt, imm);
    legal  = ref_legal(fmt, imm);
    m_done = 1'b0;
    if (out_hs) begin
      void'(sb.pop_front());
      m_emitted++;
    end
    if (in_hs) begin
      if (legal) begin
        sb.push_back('{32'(m_loaded), w});
        m_loaded++;
      end else begin
        m_err = 1'b1;
      end
    end
    case (m_phase)
      0: if (st && !fin) begin
           m_phase = 1; m_emitted = 0; m_loaded = 0; m_err = 1'b0;
         end
      1: if (fin) begin
           if (sb.size() != 0) m_phase = 2;
           else begin m_phase = 0; m_done = 1'b1; end
         end
      default: if (out_hs) begin m_phase = 0; m_done = 1'b1; end
    endcase
    m_full = (m_phase == 1) && (m_emitted == int'(DEPTH));
    @(negedge clk);
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    check("full", 32'(full), 32'(m_full));
  endtask

  logic [31:0] bnd [8];

  initial begin
    bnd = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049,
            32'd4094, 32'd4095, -32'sd4096, 32'd6};
    rst = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_b(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Program 1: four words fill DEPTH, extra bundles refused
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_b(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("r_alt0_word", out_instr, 32'h002081B3);
    check("r_alt0_addr", 32'(out_addr), 32'd0);
    set_b(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("r_alt1_word", out_instr, 32'h402081B3);
    check("r_alt1_addr", 32'(out_addr), 32'd1);
    set_b(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 32'd8);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("load_word", out_instr, 32'h00812283);
    set_b(3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 1'b0, 32'd12);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("store_word", out_instr, 32'h00512623);
    check("store_addr", 32'(out_addr), 32'd3);
    set_b(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("full_flag", 32'(full), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("done_pulse", 32'(done), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("done_once", 32'(done), 32'd0);

    // Program 2: branch, stall, illegal fmt, finish with a word pending
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_b(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("branch_word", out_instr, 32'hFE208EE3);
    set_b(3'd1, 5'd7, 5'd3, 5'd0, 3'd0, 1'b0, 32'd5);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_word", out_instr, 32'hFE208EE3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    set_b(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_no_word", 32'(out_valid), 32'd0);
    set_b(3'd1, 5'd9, 5'd4, 5'd0, 3'd1, 1'b0, 32'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("addr_after_illegal", 32'(out_addr), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("drain_done", 32'(done), 32'd1);

`ifdef IMM_RANGE_CHECK_EN
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_b(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("range_err", 32'(err), 32'd1);
    check("range_drop", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a program
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_b(3'd0, 5'd1, 5'd2, 5'd3, 3'd7, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_instr", out_instr, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic st, fin, v, ordy;
      logic [2:0] f;
      logic [31:0] im;
      st  = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      fin = ($urandom_range(0, 24) == 0);
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      case ($urandom_range(0, 3))
        0:       im = 32'($urandom_range(0, 127)) - 32'd64;
        1:       im = bnd[$urandom_range(0, 7)];
        2:       im = 32'($urandom);
        default: im = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFE;
      endcase
      set_b(f, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), im);
      step(v, ordy, st, fin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
